// File: rtl/rom_load_sequencer.sv
// Steers the hps_io ioctl ROM download into CPU/sound/graphics regions and gates core reset.
// Optional running byte checksum: define ROM_LOADER_CHECKSUM_EN.
module rom_load_sequencer #(
    parameter logic [23:0] CPU_END       = 24'h010000,
    parameter logic [23:0] SND_END       = 24'h011000,
    parameter logic [23:0] GFX_END       = 24'h021000,
    parameter int unsigned SETTLE_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [2:0]  rom_we,
    output logic [23:0] rom_addr,
    output logic [15:0] rom_data,
    input  logic        rom_ack,
    output logic [7:0]  mod,
    output logic [63:0] dip,
    output logic        core_reset,
    output logic        load_done,
    output logic        err,
    output logic [15:0] checksum
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t           state_q;
    logic             pending_q;
    logic [2:0]       we_q;
    logic [23:0]      addr_q;
    logic [15:0]      data_q;
    logic [7:0]       mod_q;
    logic [63:0]      dip_q;
    logic             core_reset_q;
    logic             load_done_q;
    logic             err_q;
    logic             half_valid_q;
    logic [7:0]       half_q;
    logic [23:0]      half_addr_q;
    logic [CNT_W-1:0] settle_q;

    logic             rom_wr;
    logic             load_start;
    logic             issue_d;
    logic             latch_d;
    logic [2:0]       we_d;
    logic [23:0]      addr_d;
    logic [15:0]      data_d;
    logic [23:0]      gfx_word;

    assign rom_wr     = (state_q == S_LOAD) && ioctl_download && ioctl_wr && (ioctl_index == 8'd0);
    assign load_start = ((state_q == S_IDLE) || (state_q == S_RUN)) && ioctl_download
                        && (ioctl_index == 8'd0);
    assign gfx_word   = (ioctl_addr[23:0] - SND_END) >> 1;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        issue_d = 1'b0;
        latch_d = 1'b0;
        we_d    = 3'b000;
        addr_d  = 24'h000000;
        data_d  = 16'h0000;
        if (rom_wr && !pending_q) begin
            if (ioctl_addr < {1'b0, CPU_END}) begin
                issue_d = 1'b1;
                we_d    = 3'b001;
                addr_d  = ioctl_addr[23:0];
                data_d  = {8'h00, ioctl_dout};
            end else if (ioctl_addr < {1'b0, SND_END}) begin
                issue_d = 1'b1;
                we_d    = 3'b010;
                addr_d  = ioctl_addr[23:0] - CPU_END;
                data_d  = {8'h00, ioctl_dout};
            end else if (ioctl_addr < {1'b0, GFX_END}) begin
                if (!ioctl_addr[0]) begin
                    latch_d = 1'b1;
                end else begin
                    issue_d = 1'b1;
                    we_d    = 3'b100;
                    addr_d  = gfx_word;
                    data_d  = {ioctl_dout, half_q};
                end
            end
        end else if ((state_q == S_FLUSH) && half_valid_q && !pending_q) begin
            issue_d = 1'b1;
            we_d    = 3'b100;
            addr_d  = half_addr_q;
            data_d  = {8'h00, half_q};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            we_q         <= 3'b000;
            addr_q       <= 24'h000000;
            data_q       <= 16'h0000;
            mod_q        <= 8'hFF;
            dip_q        <= 64'h0;
            core_reset_q <= 1'b1;
            load_done_q  <= 1'b0;
            err_q        <= 1'b0;
            half_valid_q <= 1'b0;
            half_q       <= 8'h00;
            half_addr_q  <= 24'h000000;
            settle_q     <= '0;
        end else begin
            // The issuing and acknowledging edges never coincide: issue requires !pending.
            if (issue_d) begin
                pending_q <= 1'b1;
                we_q      <= we_d;
                addr_q    <= addr_d;
                data_q    <= data_d;
            end else if (pending_q && rom_ack) begin
                pending_q <= 1'b0;
                we_q      <= 3'b000;
            end

            if (rom_wr && pending_q) begin
                err_q <= 1'b1;
            end

            if (latch_d) begin
                half_valid_q <= 1'b1;
                half_q       <= ioctl_dout;
                half_addr_q  <= gfx_word;
            end else if (issue_d && we_d[2]) begin
                half_valid_q <= 1'b0;
            end

            if (ioctl_wr && (ioctl_index == 8'd1)) begin
                mod_q <= ioctl_dout;
            end
            if (ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr < 25'd8)) begin
                dip_q[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
            end

            case (state_q)
                S_IDLE, S_RUN: begin
                    if (load_start) begin
                        state_q      <= S_LOAD;
                        core_reset_q <= 1'b1;
                        half_valid_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (!ioctl_download && (ioctl_index == 8'd0)) begin
                        settle_q <= '0;
                        state_q  <= half_valid_q ? S_FLUSH : S_SETTLE;
                    end
                end
                S_FLUSH: begin
                    if (!half_valid_q && pending_q && rom_ack) begin
                        settle_q <= '0;
                        state_q  <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == CNT_W'(SETTLE_CYCLES)) begin
                        state_q      <= S_RUN;
                        core_reset_q <= 1'b0;
                        load_done_q  <= 1'b1;
                    end else begin
                        settle_q <= settle_q + CNT_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q;
    logic [15:0] sum_add_d;

    always_comb begin
        sum_add_d = {8'h00, ioctl_dout};
        if (state_q == S_FLUSH) begin
            sum_add_d = {8'h00, half_q};
        end else if (we_d[2] && half_valid_q) begin
            sum_add_d = {8'h00, ioctl_dout} + {8'h00, half_q};
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || load_start) begin
            checksum_q <= 16'h0000;
        end else if (issue_d) begin
            checksum_q <= checksum_q + sum_add_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign ioctl_wait = pending_q;
    assign rom_we     = we_q;
    assign rom_addr   = addr_q;
    assign rom_data   = data_q;
    assign mod        = mod_q;
    assign dip        = dip_q;
    assign core_reset = core_reset_q;
    assign load_done  = load_done_q;
    assign err        = err_q;

endmodule
